// File: rtl/data_memory_port_if.sv
// Bus bundle for data_memory_port: functional-unit request side, memory
// request/response side and CDB/store-completion outputs.

interface data_memory_port_if #(
    parameter int DATA_W   = 32,
    parameter int RSV_ID_W = 4,
    parameter int INSTR_W  = 6
);
    localparam int CDB_W = RSV_ID_W + DATA_W;

    logic                i_valid;
    logic                i_ready;
    logic [INSTR_W-1:0]  i_opcode;
    logic [RSV_ID_W-1:0] i_rsv_id;
    logic [DATA_W-1:0]   i_address;
    logic [DATA_W-1:0]   i_data;

    logic                mem_req_valid;
    logic                mem_req_ready;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_addr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                mem_rsp_valid;
    logic [DATA_W-1:0]   mem_rsp_data;

    logic [CDB_W-1:0]    o_cdb;
    logic                o_cdb_valid;
    logic                o_cdb_ready;
    logic                o_store_done;
    logic [RSV_ID_W-1:0] o_store_done_id;
    logic                o_rsp_error;

    modport slave (
        input  i_valid, i_opcode, i_rsv_id, i_address, i_data,
        output i_ready,
        output mem_req_valid, mem_we, mem_addr, mem_wdata,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_data,
        output o_cdb, o_cdb_valid,
        input  o_cdb_ready,
        output o_store_done, o_store_done_id, o_rsp_error
    );

    modport master (
        output i_valid, i_opcode, i_rsv_id, i_address, i_data,
        input  i_ready,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata,
        output mem_req_ready, mem_rsp_valid, mem_rsp_data,
        input  o_cdb, o_cdb_valid,
        output o_cdb_ready,
        input  o_store_done, o_store_done_id, o_rsp_error
    );
endinterface

// File: rtl/data_memory_port.sv
// Shared FCPU widths/opcodes and the load/store port between the memory
// functional unit and the data memory. One request register feeds the
// memory bus; a small in-order queue collects load results for the CDB.

package fcpu_pkg;
    localparam int DATA_W   = 32;
    localparam int RSV_ID_W = 4;
    localparam int INSTR_W  = 6;
    localparam int CDB_W    = RSV_ID_W + DATA_W;

    localparam logic [INSTR_W-1:0] I_LOAD    = 6'h10;
    localparam logic [INSTR_W-1:0] I_LOADB   = 6'h11;
    localparam logic [INSTR_W-1:0] I_LOADR   = 6'h12;
    localparam logic [INSTR_W-1:0] I_STORE   = 6'h14;
    localparam logic [INSTR_W-1:0] I_STOREB  = 6'h15;
    localparam logic [INSTR_W-1:0] I_STORER  = 6'h16;
    localparam logic [INSTR_W-1:0] I_STOREF  = 6'h17;
    localparam logic [INSTR_W-1:0] I_STOREBF = 6'h18;
    localparam logic [INSTR_W-1:0] I_STORERF = 6'h19;
endpackage

module data_memory_port
    import fcpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              nrst,
    data_memory_port_if.slave bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    function automatic logic is_store(input logic [INSTR_W-1:0] op);
        case (op)
            I_STORE, I_STOREB, I_STORER,
            I_STOREF, I_STOREBF, I_STORERF: return 1'b1;
            default:                        return 1'b0;
        endcase
    endfunction

    // Request register
    logic                req_valid_q;
    logic                req_we_q;
    logic [RSV_ID_W-1:0] req_tag_q;
    logic [DATA_W-1:0]   req_addr_q;
    logic [DATA_W-1:0]   req_data_q;

    // Load tag/result queue
    logic [RSV_ID_W-1:0] tag_q  [DEPTH];
    logic [DATA_W-1:0]   data_q [DEPTH];
    logic [DEPTH-1:0]    filled_q;
    ptr_t                head_q;
    ptr_t                tail_q;
    ptr_t                fill_q;
    cnt_t                count_q;
    cnt_t                count_d;
    cnt_t                unfilled_q;
    cnt_t                unfilled_d;

    // Status outputs
    logic                store_done_q;
    logic [RSV_ID_W-1:0] store_done_id_q;
    logic                rsp_error_q;

    logic in_store;
    logic req_fire;
    logic slot_free;
    logic q_space;
    logic accept_ok;
    logic accept;
    logic push;
    logic fill_ok;
    logic pop;
    logic head_filled;

    assign in_store    = is_store(bus.i_opcode);
    assign req_fire    = req_valid_q & bus.mem_req_ready;
    assign slot_free   = ~req_valid_q | req_fire;
    assign q_space     = (count_q < cnt_t'(DEPTH));
    assign accept_ok   = ~nrst & slot_free & (in_store | q_space);
    assign accept      = bus.i_valid & accept_ok;
    assign push        = accept & ~in_store;
    assign head_filled = filled_q[head_q];
    assign pop         = head_filled & bus.o_cdb_ready;
    // A separate unfilled counter is used instead of comparing fill and tail
    // pointers: with DEPTH loads all outstanding, fill==tail yet a response
    // is legitimately expected.
    assign fill_ok     = bus.mem_rsp_valid & (unfilled_q != '0);

    // Next occupancy: push, fill and pop in one cycle all count
    always_comb begin
        count_d    = count_q + cnt_t'(push) - cnt_t'(pop);
        unfilled_d = unfilled_q + cnt_t'(push) - cnt_t'(fill_ok);
    end

    // Request register: load on accept, hold until the memory takes it
    always_ff @(posedge clk) begin
        if (nrst) begin
            req_valid_q <= 1'b0;
            req_we_q    <= 1'b0;
            req_tag_q   <= '0;
            req_addr_q  <= '0;
            req_data_q  <= '0;
        end else if (accept) begin
            req_valid_q <= 1'b1;
            req_we_q    <= in_store;
            req_tag_q   <= bus.i_rsv_id;
            req_addr_q  <= bus.i_address;
            req_data_q  <= bus.i_data;
        end else if (req_fire) begin
            req_valid_q <= 1'b0;
        end
    end

    // Result queue: allocate at tail, fill in response order, pop at head
    always_ff @(posedge clk) begin
        if (nrst) begin
            filled_q   <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            fill_q     <= '0;
            count_q    <= '0;
            unfilled_q <= '0;
        end else begin
            if (push) begin
                tag_q[tail_q]    <= bus.i_rsv_id;
                filled_q[tail_q] <= 1'b0;
                tail_q           <= tail_q + ptr_t'(1);
            end
            if (fill_ok) begin
                data_q[fill_q]   <= bus.mem_rsp_data;
                filled_q[fill_q] <= 1'b1;
                fill_q           <= fill_q + ptr_t'(1);
            end
            if (pop) begin
                filled_q[head_q] <= 1'b0;
                head_q           <= head_q + ptr_t'(1);
            end
            count_q    <= count_d;
            unfilled_q <= unfilled_d;
        end
    end

    // Store completion pulse and sticky unexpected-response flag
    always_ff @(posedge clk) begin
        if (nrst) begin
            store_done_q    <= 1'b0;
            store_done_id_q <= '0;
            rsp_error_q     <= 1'b0;
        end else begin
            store_done_q    <= req_fire & req_we_q;
            store_done_id_q <= req_tag_q;
            rsp_error_q     <= rsp_error_q | (bus.mem_rsp_valid & (unfilled_q == '0));
        end
    end

    assign bus.i_ready         = accept_ok;
    assign bus.mem_req_valid   = req_valid_q;
    assign bus.mem_we          = req_we_q;
    assign bus.mem_addr        = req_addr_q;
    assign bus.mem_wdata       = req_data_q;
    assign bus.o_cdb_valid     = head_filled;
    assign bus.o_cdb           = {tag_q[head_q], data_q[head_q]};
    assign bus.o_store_done    = store_done_q;
    assign bus.o_store_done_id = store_done_id_q;
    assign bus.o_rsp_error     = rsp_error_q;

endmodule

// File: tb/tb_data_memory_port.sv
// Bench for data_memory_port: random traffic against a queue-based
// reference model, plus directed latency/backpressure/error/reset cases.

module tb_data_memory_port;
    import fcpu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        logic                we;
        logic [RSV_ID_W-1:0] tag;
        logic [DATA_W-1:0]   addr;
        logic [DATA_W-1:0]   data;
    } req_t;

    typedef struct {
        logic [RSV_ID_W-1:0] tag;
        logic [DATA_W-1:0]   data;
    } res_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                due;
    } rsp_t;

    logic clk  = 1'b0;
    logic nrst = 1'b1;
    always #5 clk = ~clk;

    data_memory_port_if #(.DATA_W(DATA_W), .RSV_ID_W(RSV_ID_W), .INSTR_W(INSTR_W)) bus ();

    data_memory_port #(.DEPTH(DEPTH)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model: accepted-not-issued requests, accepted-not-popped
    // loads (with expected data), and how many leading loads are visible.
    req_t                pend_q[$];
    res_t                res_q[$];
    int                  filled_cnt = 0;
    bit                  exp_err    = 1'b0;
    bit                  exp_sd     = 1'b0;
    logic [RSV_ID_W-1:0] exp_sd_id  = '0;
    bit                  rst_edge_seen = 1'b0;
    logic [DATA_W-1:0]   ref_mem [16];

    // Memory device behind the port
    logic [DATA_W-1:0]   dev_mem [16];
    rsp_t                rsp_q[$];
    int                  last_due = 0;

    // Stimulus knobs
    int                  p_valid    = 0;
    int                  p_mready   = 100;
    int                  p_cready   = 100;
    int                  lat_min    = 1;
    int                  lat_max    = 1;
    int                  issue_left = 0;
    int                  op_mode    = 0;   // 0 mixed, 1 loads, 2 fixed
    int                  rst_cnt    = 0;
    bit                  inject_rsp = 1'b0;
    logic [INSTR_W-1:0]  fix_op     = '0;
    req_t                fix_req;
    int                  acc_cyc    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic bit store_op(input logic [INSTR_W-1:0] op);
        return op inside {I_STORE, I_STOREB, I_STORER, I_STOREF, I_STOREBF, I_STORERF};
    endfunction

    function automatic logic [INSTR_W-1:0] rand_store_op();
        case ($urandom_range(5))
            0:       return I_STORE;
            1:       return I_STOREB;
            2:       return I_STORER;
            3:       return I_STOREF;
            4:       return I_STOREBF;
            default: return I_STORERF;
        endcase
    endfunction

    function automatic int widx(input logic [DATA_W-1:0] a);
        return int'(a[5:2]);
    endfunction

    // One clock: drive, compare against the model, let the device react,
    // then advance the model to the state after the coming edge.
    task automatic cycle();
        req_t               r;
        req_t               h;
        res_t               t;
        rsp_t               nr;
        logic [INSTR_W-1:0] op;
        logic [DATA_W-1:0]  rsp_d;
        logic [DATA_W-1:0]  a;
        bit                 rsp_drv, exp_ready, acc, hs, pop, in_rst;
        int                 unfilled;

        @(posedge clk);
        #1;
        cyc++;
        nrst = (rst_cnt > 0);
        if (rst_cnt > 0) rst_cnt--;

        if (op_mode == 2) begin
            op = fix_op;
            r  = fix_req;
        end else begin
            r.tag  = RSV_ID_W'($urandom);
            r.addr = DATA_W'(($urandom_range(3) << 8) | ($urandom_range(15) << 2));
            r.data = $urandom;
            if (op_mode == 0 && $urandom_range(99) < 40) op = rand_store_op();
            else begin
                op = INSTR_W'($urandom);
                if (store_op(op)) op = I_LOAD;
            end
        end
        r.we = store_op(op);

        bus.i_valid       = (issue_left != 0) && ($urandom_range(99) < p_valid);
        bus.i_opcode      = op;
        bus.i_rsv_id      = r.tag;
        bus.i_address     = r.addr;
        bus.i_data        = r.data;
        bus.mem_req_ready = ($urandom_range(99) < p_mready);
        bus.o_cdb_ready   = ($urandom_range(99) < p_cready);

        rsp_drv = 1'b0;
        rsp_d   = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            nr      = rsp_q.pop_front();
            rsp_drv = 1'b1;
            rsp_d   = nr.data;
        end else if (inject_rsp) begin
            rsp_drv    = 1'b1;
            rsp_d      = $urandom;
            inject_rsp = 1'b0;
        end
        bus.mem_rsp_valid = rsp_drv;
        bus.mem_rsp_data  = rsp_d;

        #1;
        in_rst    = nrst;
        exp_ready = !in_rst && (pend_q.size() == 0 || bus.mem_req_ready)
                    && (r.we || res_q.size() < DEPTH);

        check("i_ready", bus.i_ready, exp_ready);
        if (in_rst) begin
            if (rst_edge_seen) begin
                check("rst_mem_req_valid", bus.mem_req_valid, 0);
                check("rst_cdb_valid", bus.o_cdb_valid, 0);
                check("rst_store_done", bus.o_store_done, 0);
                check("rst_rsp_error", bus.o_rsp_error, 0);
            end
        end else begin
            check("mem_req_valid", bus.mem_req_valid, pend_q.size() > 0);
            if (pend_q.size() > 0) begin
                check("mem_we", bus.mem_we, pend_q[0].we);
                check("mem_addr", bus.mem_addr, pend_q[0].addr);
                if (pend_q[0].we) check("mem_wdata", bus.mem_wdata, pend_q[0].data);
            end
            check("cdb_valid", bus.o_cdb_valid, filled_cnt > 0);
            if (filled_cnt > 0) check("cdb", bus.o_cdb, {res_q[0].tag, res_q[0].data});
            check("store_done", bus.o_store_done, exp_sd);
            if (exp_sd) check("store_done_id", bus.o_store_done_id, exp_sd_id);
            check("rsp_error", bus.o_rsp_error, exp_err);
        end

        // Device reacts to whatever the port actually presents
        if (bus.mem_req_valid === 1'b1 && bus.mem_req_ready) begin
            a = bus.mem_addr;
            if (bus.mem_we) dev_mem[widx(a)] = bus.mem_wdata;
            else begin
                nr.data = dev_mem[widx(a)];
                nr.due  = cyc + int'($urandom_range(lat_max, lat_min));
                if (nr.due <= last_due) nr.due = last_due + 1;
                last_due = nr.due;
                rsp_q.push_back(nr);
            end
        end

        if (in_rst) begin
            pend_q.delete();
            res_q.delete();
            filled_cnt = 0;
            exp_err    = 1'b0;
            exp_sd     = 1'b0;
            foreach (ref_mem[i]) ref_mem[i] = dev_mem[i];
            rst_edge_seen = 1'b1;
        end else begin
            acc      = bus.i_valid && exp_ready;
            hs       = (pend_q.size() > 0) && bus.mem_req_ready;
            pop      = (filled_cnt > 0) && bus.o_cdb_ready;
            unfilled = res_q.size() - filled_cnt;
            exp_sd   = 1'b0;
            if (hs) begin
                h = pend_q.pop_front();
                if (h.we) begin
                    exp_sd    = 1'b1;
                    exp_sd_id = h.tag;
                end
            end
            if (pop) begin
                t = res_q.pop_front();
                filled_cnt--;
            end
            if (rsp_drv) begin
                if (unfilled == 0) exp_err = 1'b1;
                else filled_cnt++;
            end
            if (acc) begin
                pend_q.push_back(r);
                if (r.we) ref_mem[widx(r.addr)] = r.data;
                else begin
                    t.tag  = r.tag;
                    t.data = ref_mem[widx(r.addr)];
                    res_q.push_back(t);
                end
                issue_left--;
                acc_cyc = cyc;
            end
            rst_edge_seen = 1'b0;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (k < 300 && !(pend_q.size() == 0 && res_q.size() == 0 && rsp_q.size() == 0
                            && issue_left == 0 && rst_cnt == 0)) begin
            cycle();
            k++;
        end
        if (k >= 300) check("drain_timeout", 0, 1);
        cycle();
    endtask

    initial begin
        bit got;

        foreach (dev_mem[i]) begin
            dev_mem[i] = $urandom;
            ref_mem[i] = dev_mem[i];
        end
        bus.i_valid       = 1'b0;
        bus.i_opcode      = '0;
        bus.i_rsv_id      = '0;
        bus.i_address     = '0;
        bus.i_data        = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = '0;
        bus.o_cdb_ready   = 1'b0;
        fix_req.we   = 1'b0;
        fix_req.tag  = '0;
        fix_req.addr = '0;
        fix_req.data = '0;

        rst_cnt = 3;
        repeat (5) cycle();

        // Single load, 1-cycle memory: result three cycles after accept
        dev_mem[0] = 32'hDEADBEEF;
        ref_mem[0] = 32'hDEADBEEF;
        op_mode = 2;
        fix_op  = I_LOAD;
        fix_req.tag = RSV_ID_W'(3); fix_req.addr = 32'h100; fix_req.data = '0;
        p_valid = 100; p_mready = 100; p_cready = 100;
        lat_min = 1; lat_max = 1; issue_left = 1;
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            cycle();
            if (bus.o_cdb_valid === 1'b1) begin
                got = 1'b1;
                check("ld_latency", cyc - acc_cyc, 3);
                check("ld_cdb", bus.o_cdb, {RSV_ID_W'(3), 32'hDEADBEEF});
            end
        end
        if (!got) check("ld_timeout", 0, 1);
        drain();

        // Store held by memory backpressure for two cycles
        fix_op = I_STORE;
        fix_req.tag = RSV_ID_W'(5); fix_req.addr = 32'h40; fix_req.data = 32'h12;
        p_mready = 0; issue_left = 1;
        cycle();
        cycle();
        cycle();
        check("st_held_valid", bus.mem_req_valid, 1);
        check("st_held_addr", bus.mem_addr, 32'h40);
        p_mready = 100;
        cycle();
        cycle();
        check("st_done", bus.o_store_done, 1);
        check("st_done_id", bus.o_store_done_id, 5);
        cycle();
        check("st_done_once", bus.o_store_done, 0);
        drain();

        // Five loads into a four-entry queue with the CDB stalled
        op_mode = 1; p_cready = 0; issue_left = 5;
        repeat (10) cycle();
        check("full_i_ready", bus.i_ready, 0);
        check("full_cdb_valid", bus.o_cdb_valid, 1);
        p_cready = 100;
        drain();

        // Full queue with response and pop landing in the same cycle
        issue_left = 4;
        drain();
        issue_left = 8; lat_min = 2; lat_max = 3; p_cready = 50;
        drain();
        p_cready = 100;

        // Response with nothing outstanding
        inject_rsp = 1'b1;
        cycle();
        cycle();
        check("err_set", bus.o_rsp_error, 1);
        check("err_no_cdb", bus.o_cdb_valid, 0);
        repeat (3) cycle();
        check("err_sticky", bus.o_rsp_error, 1);

        // Reset with two loads in flight
        issue_left = 2; lat_min = 6; lat_max = 6;
        repeat (3) cycle();
        issue_left = 0;
        rst_cnt = 2;
        repeat (3) cycle();
        check("post_rst_cdb_valid", bus.o_cdb_valid, 0);
        check("post_rst_i_ready", bus.i_ready, 1);
        check("post_rst_err", bus.o_rsp_error, 0);
        drain();
        check("stale_rsp_err", bus.o_rsp_error, 1);
        rst_cnt = 2;
        repeat (3) cycle();

        // Random traffic, a mid-stream reset, more random traffic
        op_mode = 0; p_valid = 60; p_mready = 70; p_cready = 60;
        lat_min = 1; lat_max = 4; issue_left = 1000000;
        repeat (1500) cycle();
        issue_left = 0; rst_cnt = 2;
        p_cready = 100;
        drain();
        rst_cnt = 2;
        repeat (3) cycle();
        p_cready = 60; issue_left = 1000000;
        repeat (1500) cycle();
        issue_left = 0; p_cready = 100;
        drain();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
